// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road traffic phase controller.
// State encoding, lamp codes and the per-road lamp decode.
package traffic_pkg;

   localparam int unsigned LAMP_W = 3;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALL_RED_1 = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALL_RED_2 = 3'd5,
      PED_WALK  = 3'd6,
      FLASH     = 3'd7
   } state_t;

   localparam logic [LAMP_W-1:0] LAMP_R   = 3'b100;
   localparam logic [LAMP_W-1:0] LAMP_Y   = 3'b010;
   localparam logic [LAMP_W-1:0] LAMP_G   = 3'b001;
   localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;

   // Lamp for one road; is_ns selects which road's green/yellow states apply.
   function automatic logic [LAMP_W-1:0] road_lamp(input state_t s, input logic phase,
                                                   input logic is_ns);
      logic [LAMP_W-1:0] lamp;
      lamp = LAMP_R;
      case (s)
         NS_GREEN:  if (is_ns)  lamp = LAMP_G;
         NS_YELLOW: if (is_ns)  lamp = LAMP_Y;
         EW_GREEN:  if (!is_ns) lamp = LAMP_G;
         EW_YELLOW: if (!is_ns) lamp = LAMP_Y;
         FLASH:     lamp = phase ? LAMP_Y : LAMP_OFF;
         default:   lamp = LAMP_R;
      endcase
      return lamp;
   endfunction

endpackage

// File: rtl/traffic_phase_controller_rise_detect.sv
// Rising-edge detector with an optional 2-flop synchronizer in front.
// RST_VAL presets the history flop so a level already high at reset gives no edge.
module rise_detect #(
   parameter bit SYNC    = 1'b0,
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_rise_c
);

   logic w_level;
   logic r_prev;

   if (SYNC) begin : g_sync
      logic r_sync1;
      logic r_sync2;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
         end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
         end
      end

      assign w_level = r_sync2;
   end else begin : g_direct
      assign w_level = i_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_prev <= RST_VAL;
      else     r_prev <= w_level;
   end

   assign o_rise_c = w_level & ~r_prev;

endmodule

// File: rtl/traffic_phase_controller.sv
// NS/EW traffic-light sequencer with pedestrian walk phase and maintenance flash.
// Second ticks come from rising edges of the 1 Hz divider level.
module traffic_phase_controller
   import traffic_pkg::*;
#(
   parameter int unsigned T_GREEN  = 20,
   parameter int unsigned T_YELLOW = 3,
   parameter int unsigned T_ALLRED = 1,
   parameter int unsigned T_WALK   = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              oneHz_clk,
   input  logic              ped_btn,
   input  logic              flash_mode,
   output logic [LAMP_W-1:0] ns_light,
   output logic [LAMP_W-1:0] ew_light,
   output logic              walk,
   output logic              ped_pending,
   output logic [CNT_W-1:0]  remaining
);

   logic w_tick;
   logic w_ped_rise;

   state_t            r_state;
   logic [CNT_W-1:0]  r_remaining;
   logic              r_phase;
   logic              r_pending;
   logic [LAMP_W-1:0] r_ns;
   logic [LAMP_W-1:0] r_ew;
   logic              r_walk;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_rem_nxt;
   logic             w_phase_nxt;
   logic             w_pend_nxt;

   rise_detect #(.SYNC(1'b0), .RST_VAL(1'b1)) u_tick_det (
      .clk      (clk),
      .rst      (rst),
      .i_d      (oneHz_clk),
      .o_rise_c (w_tick)
   );

   rise_detect #(.SYNC(1'b1), .RST_VAL(1'b0)) u_ped_det (
      .clk      (clk),
      .rst      (rst),
      .i_d      (ped_btn),
      .o_rise_c (w_ped_rise)
   );

   function automatic logic [CNT_W-1:0] duration(input state_t s);
      case (s)
         NS_GREEN, EW_GREEN:   return CNT_W'(T_GREEN);
         NS_YELLOW, EW_YELLOW: return CNT_W'(T_YELLOW);
         PED_WALK:             return CNT_W'(T_WALK);
         FLASH:                return '0;
         default:              return CNT_W'(T_ALLRED);
      endcase
   endfunction

   // Next state, countdown, flash phase and pending latch; flash overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_remaining;
      w_phase_nxt = r_phase;
      w_pend_nxt  = r_pending;

      if (flash_mode) begin
         w_state_nxt = FLASH;
         w_rem_nxt   = '0;
         if (r_state != FLASH) w_phase_nxt = 1'b1;
         else if (w_tick)      w_phase_nxt = ~r_phase;
      end else if (r_state == FLASH) begin
         w_state_nxt = ALL_RED_2;
         w_rem_nxt   = CNT_W'(T_ALLRED);
         w_phase_nxt = 1'b0;
      end else begin
         if (w_ped_rise && r_state != PED_WALK) w_pend_nxt = 1'b1;

         if (w_tick) begin
            if (r_remaining <= CNT_W'(1)) begin
               case (r_state)
                  NS_GREEN:  w_state_nxt = NS_YELLOW;
                  NS_YELLOW: w_state_nxt = ALL_RED_1;
                  ALL_RED_1: w_state_nxt = EW_GREEN;
                  EW_GREEN:  w_state_nxt = EW_YELLOW;
                  EW_YELLOW: w_state_nxt = ALL_RED_2;
                  ALL_RED_2: w_state_nxt = r_pending ? PED_WALK : NS_GREEN;
                  default:   w_state_nxt = NS_GREEN;
               endcase
               w_rem_nxt = duration(w_state_nxt);
            end else begin
               w_rem_nxt = r_remaining - CNT_W'(1);
            end
         end

         // Entering the walk phase serves the request, even against a same-cycle press.
         if (w_state_nxt == PED_WALK && r_state != PED_WALK) w_pend_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ALL_RED_2;
         r_remaining <= CNT_W'(T_ALLRED);
         r_phase     <= 1'b0;
         r_pending   <= 1'b0;
         r_ns        <= LAMP_R;
         r_ew        <= LAMP_R;
         r_walk      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_rem_nxt;
         r_phase     <= w_phase_nxt;
         r_pending   <= w_pend_nxt;
         r_ns        <= road_lamp(w_state_nxt, w_phase_nxt, 1'b1);
         r_ew        <= road_lamp(w_state_nxt, w_phase_nxt, 1'b0);
         r_walk      <= (w_state_nxt == PED_WALK);
      end
   end

   assign ns_light    = r_ns;
   assign ew_light    = r_ew;
   assign walk        = r_walk;
   assign ped_pending = r_pending;
   assign remaining   = r_remaining;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller with shortened phase durations.
// A fast oneHz_clk model produces one second tick per call of one_tick.
module tb_traffic_phase_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       oneHz_clk;
   logic       ped_btn;
   logic       flash_mode;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       walk;
   logic       ped_pending;
   logic [7:0] remaining;

   int n_checks = 0;
   int n_fail   = 0;

   // {ns, ew, remaining} after each tick of one full cycle, index 0 = NS_GREEN entry
   logic [13:0] cyc_tbl [14];

   traffic_phase_controller #(
      .T_GREEN  (4),
      .T_YELLOW (2),
      .T_ALLRED (1),
      .T_WALK   (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .oneHz_clk   (oneHz_clk),
      .ped_btn     (ped_btn),
      .flash_mode  (flash_mode),
      .ns_light    (ns_light),
      .ew_light    (ew_light),
      .walk        (walk),
      .ped_pending (ped_pending),
      .remaining   (remaining)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                          input logic wk, input logic pend, input logic [7:0] rem);
      chk({tag, ".ns"},   32'(ns_light),    32'(ns));
      chk({tag, ".ew"},   32'(ew_light),    32'(ew));
      chk({tag, ".walk"}, 32'(walk),        32'(wk));
      chk({tag, ".pend"}, 32'(ped_pending), 32'(pend));
      chk({tag, ".rem"},  32'(remaining),   32'(rem));
   endtask

   task automatic one_tick();
      @(negedge clk) oneHz_clk = 1'b1;
      repeat (3) @(negedge clk);
      oneHz_clk = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic cyc_check(input string tag, input int k, input logic pend);
      logic [13:0] e;
      e = cyc_tbl[k];
      chk_out($sformatf("%s%0d", tag, k), e[13:11], e[10:8], 1'b0, pend, e[7:0]);
   endtask

   task automatic run_cycle(input string tag, input int from, input int to, input logic pend);
      for (int k = from; k <= to; k++) begin
         one_tick();
         cyc_check(tag, k, pend);
      end
   endtask

   task automatic press_pulse(input string tag);
      @(negedge clk) ped_btn = 1'b1;
      @(negedge clk) ped_btn = 1'b0;
      @(negedge clk);
      chk({tag, ".pend_2clk"}, 32'(ped_pending), 32'd0);
      @(negedge clk);
      chk({tag, ".pend_3clk"}, 32'(ped_pending), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      cyc_tbl[0]  = {3'b001, 3'b100, 8'd4};
      cyc_tbl[1]  = {3'b001, 3'b100, 8'd3};
      cyc_tbl[2]  = {3'b001, 3'b100, 8'd2};
      cyc_tbl[3]  = {3'b001, 3'b100, 8'd1};
      cyc_tbl[4]  = {3'b010, 3'b100, 8'd2};
      cyc_tbl[5]  = {3'b010, 3'b100, 8'd1};
      cyc_tbl[6]  = {3'b100, 3'b100, 8'd1};
      cyc_tbl[7]  = {3'b100, 3'b001, 8'd4};
      cyc_tbl[8]  = {3'b100, 3'b001, 8'd3};
      cyc_tbl[9]  = {3'b100, 3'b001, 8'd2};
      cyc_tbl[10] = {3'b100, 3'b001, 8'd1};
      cyc_tbl[11] = {3'b100, 3'b010, 8'd2};
      cyc_tbl[12] = {3'b100, 3'b010, 8'd1};
      cyc_tbl[13] = {3'b100, 3'b100, 8'd1};

      rst        = 1'b1;
      oneHz_clk  = 1'b1;
      ped_btn    = 1'b0;
      flash_mode = 1'b0;
      repeat (3) @(negedge clk);
      chk_out("reset", 3'b100, 3'b100, 1'b0, 1'b0, 8'd1);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk_out("no_spurious_tick", 3'b100, 3'b100, 1'b0, 1'b0, 8'd1);
      oneHz_clk = 1'b0;
      repeat (3) @(negedge clk);

      // 1: reset-state expiry then one full 14-tick cycle
      one_tick();
      cyc_check("t1_", 0, 1'b0);
      run_cycle("t1_", 1, 13, 1'b0);
      one_tick();
      cyc_check("t1_wrap", 0, 1'b0);

      // 2: request during EW_GREEN is served after ALL_RED_2
      run_cycle("t2_", 1, 7, 1'b0);
      press_pulse("t2_press");
      run_cycle("t2_", 8, 13, 1'b1);
      one_tick();
      chk_out("t2_walk3", 3'b100, 3'b100, 1'b1, 1'b0, 8'd3);
      one_tick();
      chk_out("t2_walk2", 3'b100, 3'b100, 1'b1, 1'b0, 8'd2);
      one_tick();
      chk_out("t2_walk1", 3'b100, 3'b100, 1'b1, 1'b0, 8'd1);
      one_tick();
      cyc_check("t2_after_walk", 0, 1'b0);

      // 3: presses and a held button during PED_WALK are ignored
      press_pulse("t3_press");
      run_cycle("t3_", 1, 13, 1'b1);
      one_tick();
      chk_out("t3_walk3", 3'b100, 3'b100, 1'b1, 1'b0, 8'd3);
      @(negedge clk) ped_btn = 1'b1;
      one_tick();
      chk_out("t3_hold_walk2", 3'b100, 3'b100, 1'b1, 1'b0, 8'd2);
      one_tick();
      chk_out("t3_hold_walk1", 3'b100, 3'b100, 1'b1, 1'b0, 8'd1);
      run_cycle("t3_hold", 0, 2, 1'b0);
      ped_btn = 1'b0;
      run_cycle("t3_", 3, 13, 1'b0);
      one_tick();
      cyc_check("t3_no_walk", 0, 1'b0);

      // 4: flash mid-NS_GREEN, yellow blinks per tick, exit through ALL_RED_2
      run_cycle("t4_", 1, 2, 1'b0);
      @(negedge clk) flash_mode = 1'b1;
      @(negedge clk);
      chk_out("t4_flash_on", 3'b010, 3'b010, 1'b0, 1'b0, 8'd0);
      one_tick();
      chk_out("t4_flash_off", 3'b000, 3'b000, 1'b0, 1'b0, 8'd0);
      one_tick();
      chk_out("t4_flash_on2", 3'b010, 3'b010, 1'b0, 1'b0, 8'd0);
      @(negedge clk) flash_mode = 1'b0;
      @(negedge clk);
      chk_out("t4_exit_ar2", 3'b100, 3'b100, 1'b0, 1'b0, 8'd1);
      one_tick();
      cyc_check("t4_resume", 0, 1'b0);

      // 5: asynchronous reset mid-EW_YELLOW with a pending request
      press_pulse("t5_press");
      run_cycle("t5_", 1, 11, 1'b1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_out("t5_async_rst", 3'b100, 3'b100, 1'b0, 1'b0, 8'd1);
      oneHz_clk = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk_out("t5_no_tick_after_rel", 3'b100, 3'b100, 1'b0, 1'b0, 8'd1);
      oneHz_clk = 1'b0;
      repeat (2) @(negedge clk);
      one_tick();
      cyc_check("t5_restart", 0, 1'b0);

      // 6: a constant oneHz_clk level freezes the countdown
      repeat (100) @(negedge clk);
      cyc_check("t6_frozen_low", 0, 1'b0);
      oneHz_clk = 1'b1;
      repeat (100) @(negedge clk);
      cyc_check("t6_one_dec", 1, 1'b0);
      oneHz_clk = 1'b0;
      repeat (100) @(negedge clk);
      cyc_check("t6_frozen_after", 1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
